// File: rtl/uart_core_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_core_param_fifo
// Purpose  : Synchronous first-word-fall-through FIFO used by both UART paths.
// Ports    : clk, reset (async, active-high)
//            wr_en/wr_data   - push side; a push while full only lands when a
//                              pop happens in the same cycle
//            rd_en/rd_data   - pop side; rd_data shows the head entry
//                              combinationally and reads 0 while empty
//            full, empty, count - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module uart_core_param_fifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);
    localparam int              c_depth    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] c_full_cnt = {1'b1, {ADDR_W{1'b0}}};

    logic [WIDTH-1:0]  r_mem [c_depth];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_do_wr;
    logic              w_do_rd;

    assign full    = (r_count == c_full_cnt);
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign w_do_rd = rd_en && !empty;
    // When full, a push is only accepted alongside a pop (full implies non-empty).
    assign w_do_wr = wr_en && (!full || rd_en);
    assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_wr && !w_do_rd) begin
                r_count <= r_count + 1'b1;
            end else if (!w_do_wr && w_do_rd) begin
                r_count <= r_count - 1'b1;
            end
        end
    end
endmodule

// ============================================================================
// Module   : uart_core_param
// Purpose  : Full-duplex UART with shared 16x baud generator, TX and RX FIFOs,
//            runtime parity, 1/2 stop bits, sticky error flags, false-start
//            rejection and internal loopback.
// Ports    : clk, reset (async, active-high)
//            baud_div    - tick every baud_div+1 clocks (16 ticks per bit)
//            parity_mode - 00/11 none, 01 odd, 10 even
//            loopback    - internal TX feeds RX, tx pin held high
//            tx_wr_en/tx_data, tx_full, tx_count, tx_busy - transmit side
//            rx_rd_en, rx_data, rx_empty, rx_count        - receive side
//            rx, tx      - serial pins
//            err_clr, parity_err, frame_err, overrun      - sticky errors
// Revision : 1.0 - initial release
// ============================================================================
module uart_core_param #(
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            baud_div,
    input  logic [1:0]             parity_mode,
    input  logic                   loopback,
    input  logic                   tx_wr_en,
    input  logic [DATA_BITS-1:0]   tx_data,
    output logic                   tx_full,
    output logic [FIFO_ADDR_W:0]   tx_count,
    output logic                   tx_busy,
    input  logic                   rx_rd_en,
    output logic [DATA_BITS-1:0]   rx_data,
    output logic                   rx_empty,
    output logic [FIFO_ADDR_W:0]   rx_count,
    input  logic                   rx,
    output logic                   tx,
    input  logic                   err_clr,
    output logic                   parity_err,
    output logic                   frame_err,
    output logic                   overrun
);
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    localparam logic [3:0] c_last_bit = 4'(DATA_BITS - 1);
    localparam logic       c_two_stop = (STOP_BITS == 2);

    // ------------------------------------------------------------------
    // Baud tick. The limit is reloaded only on a wrap so a baud_div change
    // never truncates or stretches the period already in progress.
    // ------------------------------------------------------------------
    logic [15:0] r_baud_cnt;
    logic [15:0] r_baud_lim;
    logic        w_tick;

    assign w_tick = (r_baud_cnt == r_baud_lim);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_baud_cnt <= '0;
            r_baud_lim <= '0;
        end else if (w_tick) begin
            r_baud_cnt <= '0;
            r_baud_lim <= baud_div;
        end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end
    end

    logic w_par_en;
    logic w_par_odd;

    assign w_par_en  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
    assign w_par_odd = (parity_mode == 2'b01);

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    logic                 w_tx_pop;
    logic                 w_tx_empty;
    logic [DATA_BITS-1:0] w_tx_head;

    logic [2:0]           r_tx_state;
    logic [3:0]           r_tx_tick;
    logic [3:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par_en;
    logic                 r_tx_par;
    logic                 r_tx_stop2;
    logic                 r_tx_line;
    logic                 w_tx_bit_end;

    uart_core_param_fifo #(
        .WIDTH  (DATA_BITS),
        .ADDR_W (FIFO_ADDR_W)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_wr_en),
        .wr_data (tx_data),
        .rd_en   (w_tx_pop),
        .rd_data (w_tx_head),
        .full    (tx_full),
        .empty   (w_tx_empty),
        .count   (tx_count)
    );

    assign w_tx_pop     = (r_tx_state == c_st_idle) && !w_tx_empty;
    assign w_tx_bit_end = w_tick && (r_tx_tick == 4'd15);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_state  <= c_st_idle;
            r_tx_tick   <= '0;
            r_tx_bit    <= '0;
            r_tx_shift  <= '0;
            r_tx_par_en <= 1'b0;
            r_tx_par    <= 1'b0;
            r_tx_stop2  <= 1'b0;
            r_tx_line   <= 1'b1;
        end else begin
            // The 4-bit tick counter wraps 15->0 on its own at each bit boundary.
            if (w_tick) begin
                r_tx_tick <= r_tx_tick + 1'b1;
            end
            case (r_tx_state)
                c_st_idle: begin
                    r_tx_tick <= '0;
                    r_tx_line <= 1'b1;
                    if (w_tx_pop) begin
                        r_tx_shift  <= w_tx_head;
                        r_tx_par_en <= w_par_en;
                        r_tx_par    <= (^w_tx_head) ^ w_par_odd;
                        r_tx_line   <= 1'b0;
                        r_tx_state  <= c_st_start;
                    end
                end
                c_st_start: begin
                    if (w_tx_bit_end) begin
                        r_tx_line  <= r_tx_shift[0];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= '0;
                        r_tx_state <= c_st_data;
                    end
                end
                c_st_data: begin
                    if (w_tx_bit_end) begin
                        if (r_tx_bit == c_last_bit) begin
                            if (r_tx_par_en) begin
                                r_tx_line  <= r_tx_par;
                                r_tx_state <= c_st_parity;
                            end else begin
                                r_tx_line  <= 1'b1;
                                r_tx_stop2 <= 1'b0;
                                r_tx_state <= c_st_stop;
                            end
                        end else begin
                            r_tx_line  <= r_tx_shift[0];
                            r_tx_shift <= r_tx_shift >> 1;
                            r_tx_bit   <= r_tx_bit + 1'b1;
                        end
                    end
                end
                c_st_parity: begin
                    if (w_tx_bit_end) begin
                        r_tx_line  <= 1'b1;
                        r_tx_stop2 <= 1'b0;
                        r_tx_state <= c_st_stop;
                    end
                end
                c_st_stop: begin
                    if (w_tx_bit_end) begin
                        if (c_two_stop && !r_tx_stop2) begin
                            r_tx_stop2 <= 1'b1;
                        end else begin
                            r_tx_state <= c_st_idle;
                        end
                    end
                end
                default: begin
                    r_tx_line  <= 1'b1;
                    r_tx_state <= c_st_idle;
                end
            endcase
        end
    end

    assign tx      = loopback ? 1'b1 : r_tx_line;
    assign tx_busy = (r_tx_state != c_st_idle);

    // ------------------------------------------------------------------
    // Receive path. The loopback mux sits ahead of the synchroniser so
    // both sources share one sampling path.
    // ------------------------------------------------------------------
    logic r_rx_s1;
    logic r_rx_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
        end else begin
            r_rx_s1 <= loopback ? r_tx_line : rx;
            r_rx_s2 <= r_rx_s1;
        end
    end

    logic [2:0]           r_rx_state;
    logic [3:0]           r_rx_tick;
    logic [3:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par_en;
    logic                 r_rx_odd;
    logic                 r_rx_par_bad;
    logic                 w_rx_sample;
    logic                 w_rx_mid;
    logic                 w_rx_done;
    logic                 w_rx_full;

    // Half a bit into START, then every 16 ticks: always mid-bit.
    assign w_rx_mid    = w_tick && (r_rx_tick == 4'd7);
    assign w_rx_sample = w_tick && (r_rx_tick == 4'd15);
    assign w_rx_done   = (r_rx_state == c_st_stop) && w_rx_sample;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_state   <= c_st_idle;
            r_rx_tick    <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_rx_par_en  <= 1'b0;
            r_rx_odd     <= 1'b0;
            r_rx_par_bad <= 1'b0;
        end else begin
            if (w_tick) begin
                r_rx_tick <= r_rx_tick + 1'b1;
            end
            case (r_rx_state)
                c_st_idle: begin
                    r_rx_tick <= '0;
                    if (!r_rx_s2) begin
                        r_rx_par_en  <= w_par_en;
                        r_rx_odd     <= w_par_odd;
                        r_rx_par_bad <= 1'b0;
                        r_rx_state   <= c_st_start;
                    end
                end
                c_st_start: begin
                    if (w_rx_mid) begin
                        r_rx_tick <= '0;
                        if (r_rx_s2) begin
                            // Line went back high: a glitch, not a start bit.
                            r_rx_state <= c_st_idle;
                        end else begin
                            r_rx_bit   <= '0;
                            r_rx_state <= c_st_data;
                        end
                    end
                end
                c_st_data: begin
                    if (w_rx_sample) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                        if (r_rx_bit == c_last_bit) begin
                            r_rx_state <= r_rx_par_en ? c_st_parity : c_st_stop;
                        end else begin
                            r_rx_bit <= r_rx_bit + 1'b1;
                        end
                    end
                end
                c_st_parity: begin
                    if (w_rx_sample) begin
                        r_rx_par_bad <= r_rx_s2 ^ (^r_rx_shift) ^ r_rx_odd;
                        r_rx_state   <= c_st_stop;
                    end
                end
                c_st_stop: begin
                    // Only the first stop bit is checked; return at once so a
                    // following frame is never missed.
                    if (w_rx_sample) begin
                        r_rx_state <= c_st_idle;
                    end
                end
                default: begin
                    r_rx_state <= c_st_idle;
                end
            endcase
        end
    end

    uart_core_param_fifo #(
        .WIDTH  (DATA_BITS),
        .ADDR_W (FIFO_ADDR_W)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_rx_done),
        .wr_data (r_rx_shift),
        .rd_en   (rx_rd_en),
        .rd_data (rx_data),
        .full    (w_rx_full),
        .empty   (rx_empty),
        .count   (rx_count)
    );

    // ------------------------------------------------------------------
    // Sticky error flags; a new error beats a simultaneous clear.
    // ------------------------------------------------------------------
    logic w_par_set;
    logic w_frm_set;
    logic w_ovr_set;
    logic r_parity_err;
    logic r_frame_err;
    logic r_overrun;

    assign w_par_set = w_rx_done && r_rx_par_bad;
    assign w_frm_set = w_rx_done && !r_rx_s2;
    assign w_ovr_set = w_rx_done && w_rx_full && !rx_rd_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_parity_err <= w_par_set || (r_parity_err && !err_clr);
            r_frame_err  <= w_frm_set || (r_frame_err && !err_clr);
            r_overrun    <= w_ovr_set || (r_overrun && !err_clr);
        end
    end

    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_uart_core_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_core_param
// Purpose  : Directed self-checking bench for uart_core_param (8 data bits,
//            2 stop bits, 4-entry FIFOs). Bit period is 64 clocks (baud_div=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_core_param;
    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   baud_div;
    logic [1:0]    parity_mode;
    logic          loopback;
    logic          tx_wr_en;
    logic [DW-1:0] tx_data;
    logic          tx_full;
    logic [AW:0]   tx_count;
    logic          tx_busy;
    logic          rx_rd_en;
    logic [DW-1:0] rx_data;
    logic          rx_empty;
    logic [AW:0]   rx_count;
    logic          rx;
    logic          tx;
    logic          err_clr;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    uart_core_param #(
        .DATA_BITS   (DW),
        .STOP_BITS   (2),
        .FIFO_ADDR_W (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .loopback    (loopback),
        .tx_wr_en    (tx_wr_en),
        .tx_data     (tx_data),
        .tx_full     (tx_full),
        .tx_count    (tx_count),
        .tx_busy     (tx_busy),
        .rx_rd_en    (rx_rd_en),
        .rx_data     (rx_data),
        .rx_empty    (rx_empty),
        .rx_count    (rx_count),
        .rx          (rx),
        .tx          (tx),
        .err_clr     (err_clr),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] d);
        tx_data  = d;
        tx_wr_en = 1'b1;
        @(negedge clk);
        tx_wr_en = 1'b0;
    endtask

    task automatic pop();
        rx_rd_en = 1'b1;
        @(negedge clk);
        rx_rd_en = 1'b0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic wait_tx_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_tx_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            if (tx_busy === 1'b0 && tx_count === '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called at the cycle a start bit is seen; samples mid-bit of each bit.
    task automatic capture_frame(input int nbits, output logic [15:0] bits);
        bits = '0;
        for (int j = 0; j < nbits; j++) begin
            tick_n(j == 0 ? 32 : 64);
            bits[j] = tx;
        end
    endtask

    // Drives one frame on the rx pin. A bad stop bit is held low just long
    // enough to cover the receiver's mid-bit sample.
    task automatic send_rx(input logic [7:0] d, input bit use_par,
                           input bit par_bit, input bit bad_stop);
        rx = 1'b0;
        tick_n(64);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick_n(64);
        end
        if (use_par) begin
            rx = par_bit;
            tick_n(64);
        end
        if (bad_stop) begin
            rx = 1'b0;
            tick_n(48);
            rx = 1'b1;
            tick_n(80);
        end else begin
            rx = 1'b1;
            tick_n(128);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick_n(3);
        reset = 1'b0;
        tick_n(2);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
        checks++; if (tx_full !== 1'b0 || tx_count !== 3'd0) begin errors++; $display("FAIL reset_tx_fifo: full %b count %0d want 0/0", tx_full, tx_count); end
        checks++; if (rx_empty !== 1'b1 || rx_count !== 3'd0) begin errors++; $display("FAIL reset_rx_fifo: empty %b count %0d want 1/0", rx_empty, rx_count); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        checks++; if ({parity_err, frame_err, overrun} !== 3'b000) begin errors++; $display("FAIL reset_errs: got %b want 000", {parity_err, frame_err, overrun}); end
    endtask

    task automatic test_tx_frame();
        bit ok;
        logic [15:0] bits;
        loopback = 1'b0; parity_mode = 2'b10;
        push(8'hA5);
        wait_tx_low(ok);
        checks++; if (!ok) begin errors++; $display("FAIL tx_frame_start: no start bit seen, got tx=%b want 0", tx); end
        capture_frame(12, bits);
        // start 0, A5 LSB first 1,0,1,0,0,1,0,1, even parity 0, stop 1, stop 1
        checks++; if (bits[11:0] !== 12'hD4A) begin errors++; $display("FAIL tx_frame_bits: got %h want d4a", bits[11:0]); end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_in_stop: got %b want 1", tx_busy); end
        wait_tx_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL tx_frame_idle: got busy %b want 0", tx_busy); end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL tx_no_rx: rx_empty got %b want 1", rx_empty); end
    endtask

    task automatic test_loopback();
        int  n;
        bit  got;
        bit  pin_low;
        loopback = 1'b1; parity_mode = 2'b10;
        push(8'hA5);
        got = 1'b0; pin_low = 1'b0; n = 0;
        for (int i = 0; i < 1500; i++) begin
            if (tx !== 1'b1) pin_low = 1'b1;
            if (rx_empty === 1'b0) begin
                got = 1'b1;
                break;
            end
            n++;
            @(negedge clk);
        end
        checks++; if (!got) begin errors++; $display("FAIL loop_rx_arrive: rx_empty got %b want 0", rx_empty); end
        checks++; if (n < 650 || n > 710) begin errors++; $display("FAIL loop_latency: got %0d clk want 650..710", n); end
        checks++; if (pin_low) begin errors++; $display("FAIL loop_pin_high: tx pin went low, want constant 1"); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL loop_rx_data: got %h want a5", rx_data); end
        checks++; if ({parity_err, frame_err, overrun} !== 3'b000) begin errors++; $display("FAIL loop_errs: got %b want 000", {parity_err, frame_err, overrun}); end
        pop();
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL loop_pop: rx_empty got %b want 1", rx_empty); end
        wait_tx_idle(got);
        tick_n(20);
        loopback = 1'b0;
    endtask

    task automatic test_parity();
        loopback = 1'b0; parity_mode = 2'b01;
        // 0x3C has four ones: odd parity bit must be 1, so 0 is wrong.
        send_rx(8'h3C, 1'b1, 1'b0, 1'b0);
        checks++; if (rx_empty !== 1'b0 || rx_data !== 8'h3C) begin errors++; $display("FAIL par_bad_data: empty %b data %h want 0/3c", rx_empty, rx_data); end
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_bad_flag: got %b want 1", parity_err); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL par_bad_frame: got %b want 0", frame_err); end
        tick_n(50);
        checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL par_sticky: got %b want 1", parity_err); end
        clear_errors();
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL par_clear: got %b want 0", parity_err); end
        pop();
        send_rx(8'h3C, 1'b1, 1'b1, 1'b0);
        checks++; if (rx_data !== 8'h3C || parity_err !== 1'b0) begin errors++; $display("FAIL par_odd_ok: data %h perr %b want 3c/0", rx_data, parity_err); end
        pop();
        // 0x07 has three ones: even parity bit is 1.
        parity_mode = 2'b10;
        send_rx(8'h07, 1'b1, 1'b1, 1'b0);
        checks++; if (rx_data !== 8'h07 || parity_err !== 1'b0) begin errors++; $display("FAIL par_even_ok: data %h perr %b want 07/0", rx_data, parity_err); end
        pop();
    endtask

    task automatic test_framing();
        loopback = 1'b0; parity_mode = 2'b00;
        send_rx(8'h81, 1'b0, 1'b0, 1'b1);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_flag: got %b want 1", frame_err); end
        checks++; if (rx_count !== 3'd1 || rx_data !== 8'h81) begin errors++; $display("FAIL frame_stored: count %0d data %h want 1/81", rx_count, rx_data); end
        clear_errors();
        pop();
        // 4-tick glitch: must not start a frame
        rx = 1'b0;
        tick_n(16);
        rx = 1'b1;
        tick_n(800);
        checks++; if (rx_count !== 3'd0 || rx_empty !== 1'b1) begin errors++; $display("FAIL glitch_nowrite: count %0d empty %b want 0/1", rx_count, rx_empty); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_noerr: frame_err %b want 0", frame_err); end
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
        checks++; if (rx_count !== 3'd1 || rx_data !== 8'h5A) begin errors++; $display("FAIL after_glitch: count %0d data %h want 1/5a", rx_count, rx_data); end
        pop();
    endtask

    task automatic test_fifo_bounds();
        bit ok;
        bit saw_low;
        logic [15:0] bits;
        logic [7:0]  exp;
        loopback = 1'b0; parity_mode = 2'b00;
        for (int k = 1; k <= 5; k++) push(8'(k));
        checks++; if (tx_full !== 1'b1 || tx_count !== 3'd4) begin errors++; $display("FAIL fifo_full: full %b count %0d want 1/4", tx_full, tx_count); end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL fifo_first_pop: busy %b want 1", tx_busy); end
        push(8'h06);
        checks++; if (tx_count !== 3'd4 || tx_full !== 1'b1) begin errors++; $display("FAIL fifo_push_full: count %0d full %b want 4/1", tx_count, tx_full); end
        for (int k = 1; k <= 5; k++) begin
            exp = 8'(k);
            wait_tx_low(ok);
            capture_frame(10, bits);
            checks++; if (!ok || bits[9:0] !== {1'b1, exp, 1'b0}) begin errors++; $display("FAIL fifo_order_%0d: got %h want %h", k, bits[9:0], {1'b1, exp, 1'b0}); end
        end
        saw_low = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (tx !== 1'b1) saw_low = 1'b1;
            @(negedge clk);
        end
        checks++; if (saw_low || tx_busy !== 1'b0 || tx_count !== 3'd0) begin errors++; $display("FAIL fifo_no_sixth: low %b busy %b count %0d want 0/0/0", saw_low, tx_busy, tx_count); end
    endtask

    task automatic test_overrun();
        bit ok;
        logic [7:0] exp;
        loopback = 1'b1; parity_mode = 2'b00;
        for (int k = 0; k < 5; k++) push(8'h11 + 8'(k));
        wait_tx_idle(ok);
        tick_n(100);
        checks++; if (!ok) begin errors++; $display("FAIL ovr_tx_done: busy %b want 0", tx_busy); end
        checks++; if (rx_count !== 3'd4 || overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: count %0d overrun %b want 4/1", rx_count, overrun); end
        for (int k = 0; k < 4; k++) begin
            exp = 8'h11 + 8'(k);
            checks++; if (rx_data !== exp) begin errors++; $display("FAIL ovr_read_%0d: got %h want %h", k, rx_data, exp); end
            pop();
        end
        checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL ovr_fifth_lost: empty %b want 1", rx_empty); end
        clear_errors();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", overrun); end
        loopback = 1'b0;
    endtask

    task automatic test_reset_and_stop2();
        bit ok;
        bit found;
        int run;
        logic [15:0] bits;
        loopback = 1'b0; parity_mode = 2'b00;
        push(8'hF0);
        tick_n(300);
        reset = 1'b1;
        #1;
        checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL reset_mid: tx %b busy %b want 1/0", tx, tx_busy); end
        @(negedge clk);
        reset = 1'b0;
        tick_n(2);
        push(8'h55);
        push(8'hAA);
        wait_tx_low(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_start: no start bit, tx %b want 0", tx); end
        // 0x55 ends with a 0 data bit, so the longest high run is the stop gap:
        // 32 ticks, plus the single IDLE cycle that pops the next entry.
        run = 0; found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (tx === 1'b1) run++;
            else begin
                if (run > 64) begin
                    found = 1'b1;
                    break;
                end
                run = 0;
            end
        end
        checks++; if (!found || run < 128 || run > 129) begin errors++; $display("FAIL b2b_gap: got %0d clk want 128..129", run); end
        capture_frame(10, bits);
        checks++; if (bits[9:0] !== {1'b1, 8'hAA, 1'b0}) begin errors++; $display("FAIL b2b_second: got %h want %h", bits[9:0], {1'b1, 8'hAA, 1'b0}); end
        wait_tx_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_idle: busy %b want 0", tx_busy); end
    endtask

    initial begin
        reset = 1'b1; baud_div = 16'd3; parity_mode = 2'b00; loopback = 1'b0;
        tx_wr_en = 1'b0; tx_data = '0; rx_rd_en = 1'b0; rx = 1'b1; err_clr = 1'b0;
        test_reset();
        test_tx_frame();
        test_loopback();
        test_parity();
        test_framing();
        test_fifo_bounds();
        test_overrun();
        test_reset_and_stop2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
